// File: rtl/pipe_pkg.sv
// Shared constants for the Y86-64 pipeline stage registers: status codes,
// bubble payload encodings and the per-slot control operations.
package pipe_pkg;

    localparam int STAT_W = 3;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // nop instruction encoding, placed in the top byte of decode/execute payloads
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] IFUN_NONE = 4'h0;

    localparam logic [63:0] BUBBLE_REGD = {ICODE_NOP, IFUN_NONE, 56'h0};
    localparam logic [63:0] BUBBLE_REGE = {ICODE_NOP, IFUN_NONE, 56'h0};
    localparam logic [63:0] BUBBLE_REGM = 64'h0;

    // What a single storage slot does on the next clock edge
    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_LOAD  = 2'd1,
        SLOT_DROP  = 2'd2,  // mark invalid, keep last data/stat
        SLOT_CLEAR = 2'd3   // load bubble value, mark invalid
    } slot_op_e;

endpackage

// File: rtl/pipe_slot.sv
// One valid+data+stat storage slot with load, drop, clear-to-bubble and hold.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                 WIDTH       = 64,
    parameter int                 SW          = 3,
    parameter logic [WIDTH-1:0]   BUBBLE_DATA = {WIDTH{1'b0}},
    parameter logic [SW-1:0]      BUBBLE_STAT = {{(SW-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  slot_op_e         op,
    input  logic [WIDTH-1:0] d_data,
    input  logic [SW-1:0]    d_stat,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data,
    output logic [SW-1:0]    q_stat
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    logic [SW-1:0]    stat_r;

    // Slot register: apply the requested operation, bubble value on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= BUBBLE_DATA;
            stat_r  <= BUBBLE_STAT;
        end else begin
            case (op)
                SLOT_LOAD: begin
                    valid_r <= 1'b1;
                    data_r  <= d_data;
                    stat_r  <= d_stat;
                end
                SLOT_DROP: begin
                    valid_r <= 1'b0;
                end
                SLOT_CLEAR: begin
                    valid_r <= 1'b0;
                    data_r  <= BUBBLE_DATA;
                    stat_r  <= BUBBLE_STAT;
                end
                SLOT_HOLD: begin
                    valid_r <= valid_r;
                end
                default: begin
                    valid_r <= valid_r;
                end
            endcase
        end
    end

    assign q_valid = valid_r;
    assign q_data  = data_r;
    assign q_stat  = stat_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with ready/valid flow control, stall/bubble
// control, optional skid slot, saturating event counters and a sticky
// stall+bubble conflict flag.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                   WIDTH       = 64,
    parameter int                   STAT_W      = 3,
    parameter int                   SKID        = 1,
    parameter logic [WIDTH-1:0]     BUBBLE_DATA = {WIDTH{1'b0}},
    parameter logic [STAT_W-1:0]    BUBBLE_STAT = {{(STAT_W-1){1'b0}}, 1'b1},
    parameter int                   CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              bubble,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [STAT_W-1:0] in_stat,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [STAT_W-1:0] out_stat,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic              ctl_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    slot_op_e          m_op_s;
    slot_op_e          s_op_s;
    logic              m_from_s_s;
    logic [WIDTH-1:0]  m_d_data_s;
    logic [STAT_W-1:0] m_d_stat_s;
    logic              m_valid_s;
    logic [WIDTH-1:0]  m_data_s;
    logic [STAT_W-1:0] m_stat_s;
    logic              s_valid_s;
    logic [WIDTH-1:0]  s_data_s;
    logic [STAT_W-1:0] s_stat_s;
    logic              in_ready_s;
    logic              out_valid_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  bubble_cnt_r;
    logic              ctl_err_r;

    // Handshake: readiness depends on slot occupancy; stall, bubble and reset block both sides
    always_comb begin
        in_ready_s = 1'b0;
        if (rst || stall || bubble) begin
            in_ready_s = 1'b0;
        end else if (SKID != 0) begin
            in_ready_s = ~s_valid_s;
        end else begin
            in_ready_s = ~m_valid_s | out_ready;
        end
        out_valid_s = m_valid_s & ~stall & ~bubble;
        in_fire_s   = in_valid & in_ready_s;
        out_fire_s  = out_valid_s & out_ready;
    end

    // Slot control: bubble flushes, stall holds, otherwise move entries in FIFO order
    always_comb begin
        m_op_s     = SLOT_HOLD;
        s_op_s     = SLOT_HOLD;
        m_from_s_s = 1'b0;
        if (bubble) begin
            m_op_s = SLOT_CLEAR;
            s_op_s = SLOT_CLEAR;
        end else if (stall) begin
            m_op_s = SLOT_HOLD;
            s_op_s = SLOT_HOLD;
        end else if (SKID != 0) begin
            if (out_fire_s && s_valid_s) begin
                // in_ready is low whenever S is full, so no new entry competes here
                m_op_s     = SLOT_LOAD;
                m_from_s_s = 1'b1;
                s_op_s     = SLOT_DROP;
            end else begin
                if (in_fire_s && (!m_valid_s || out_fire_s)) begin
                    m_op_s = SLOT_LOAD;
                end else if (out_fire_s) begin
                    m_op_s = SLOT_DROP;
                end else begin
                    m_op_s = SLOT_HOLD;
                end
                if (in_fire_s && m_valid_s && !out_fire_s) begin
                    s_op_s = SLOT_LOAD;
                end else begin
                    s_op_s = SLOT_HOLD;
                end
            end
        end else begin
            if (in_fire_s) begin
                m_op_s = SLOT_LOAD;
            end else if (out_fire_s) begin
                m_op_s = SLOT_DROP;
            end else begin
                m_op_s = SLOT_HOLD;
            end
        end
    end

    assign m_d_data_s = m_from_s_s ? s_data_s : in_data;
    assign m_d_stat_s = m_from_s_s ? s_stat_s : in_stat;

    pipe_slot #(
        .WIDTH       (WIDTH),
        .SW          (STAT_W),
        .BUBBLE_DATA (BUBBLE_DATA),
        .BUBBLE_STAT (BUBBLE_STAT)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .op      (m_op_s),
        .d_data  (m_d_data_s),
        .d_stat  (m_d_stat_s),
        .q_valid (m_valid_s),
        .q_data  (m_data_s),
        .q_stat  (m_stat_s)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .WIDTH       (WIDTH),
                .SW          (STAT_W),
                .BUBBLE_DATA (BUBBLE_DATA),
                .BUBBLE_STAT (BUBBLE_STAT)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .op      (s_op_s),
                .d_data  (in_data),
                .d_stat  (in_stat),
                .q_valid (s_valid_s),
                .q_data  (s_data_s),
                .q_stat  (s_stat_s)
            );
        end else begin : g_noskid
            assign s_valid_s = 1'b0;
            assign s_data_s  = BUBBLE_DATA;
            assign s_stat_s  = BUBBLE_STAT;
        end
    endgenerate

    // Saturating stall/bubble counters and sticky stall+bubble conflict flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
            ctl_err_r    <= 1'b0;
        end else begin
            if (stall && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (bubble && (bubble_cnt_r != CNT_MAX)) begin
                bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
            end
            if (stall && bubble) begin
                ctl_err_r <= 1'b1;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_s;
    assign out_data   = m_data_s;
    assign out_stat   = m_stat_s;
    assign stall_cnt  = stall_cnt_r;
    assign bubble_cnt = bubble_cnt_r;
    assign ctl_err    = ctl_err_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: a skid instance and a single-entry instance share the
// same stimulus; each is compared every cycle against a FIFO-queue model.
module tb_pipe_stage_reg;

    localparam logic [63:0] BD0 = 64'h1000_0000_0000_0000;
    localparam logic [63:0] BD1 = 64'h0;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        bubble;
    logic        in_valid;
    logic [63:0] in_data;
    logic [2:0]  in_stat;
    logic        out_ready;

    logic        in_ready0, out_valid0, ctl_err0;
    logic [63:0] out_data0;
    logic [2:0]  out_stat0;
    logic [15:0] stall_cnt0, bubble_cnt0;
    logic        in_ready1, out_valid1, ctl_err1;
    logic [63:0] out_data1;
    logic [2:0]  out_stat1;
    logic [3:0]  stall_cnt1, bubble_cnt1;

    int checks = 0;
    int errors = 0;

    // queue model per instance (0 = skid, 1 = single entry)
    logic [63:0] qd [2][2];
    logic [2:0]  qs [2][2];
    int          qn [2];
    logic [63:0] gd [2];
    logic [2:0]  gs [2];
    int          sc [2];
    int          bc [2];
    logic        ce [2];
    logic        ifire [2];
    logic        ofire [2];

    pipe_stage_reg #(.WIDTH(64), .STAT_W(3), .SKID(1), .BUBBLE_DATA(BD0),
                     .BUBBLE_STAT(3'd1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .in_valid(in_valid), .in_data(in_data), .in_stat(in_stat),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
        .out_stat(out_stat0), .out_ready(out_ready), .stall_cnt(stall_cnt0),
        .bubble_cnt(bubble_cnt0), .ctl_err(ctl_err0));

    pipe_stage_reg #(.WIDTH(64), .STAT_W(3), .SKID(0), .BUBBLE_DATA(BD1),
                     .BUBBLE_STAT(3'd1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .in_valid(in_valid), .in_data(in_data), .in_stat(in_stat),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_stat(out_stat1), .out_ready(out_ready), .stall_cnt(stall_cnt1),
        .bubble_cnt(bubble_cnt1), .ctl_err(ctl_err1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cnt_max(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic logic [63:0] bub_data(input int k);
        return (k == 0) ? BD0 : BD1;
    endfunction

    function automatic logic exp_in_ready(input int k);
        if (rst || stall || bubble) return 1'b0;
        if (k == 0) return (qn[k] < 2);
        return (qn[k] == 0) || out_ready;
    endfunction

    function automatic logic exp_out_valid(input int k);
        return (qn[k] > 0) && !stall && !bubble;
    endfunction

    task automatic model_reset(input int k);
        qn[k] = 0;
        gd[k] = bub_data(k);
        gs[k] = 3'd1;
        sc[k] = 0;
        bc[k] = 0;
        ce[k] = 1'b0;
    endtask

    task automatic model_edge(input int k);
        if (rst) begin
            model_reset(k);
        end else begin
            if (stall && sc[k] < cnt_max(k)) sc[k] = sc[k] + 1;
            if (bubble && bc[k] < cnt_max(k)) bc[k] = bc[k] + 1;
            if (stall && bubble) ce[k] = 1'b1;
            if (bubble) begin
                qn[k] = 0;
                gd[k] = bub_data(k);
                gs[k] = 3'd1;
            end else if (!stall) begin
                if (ofire[k]) begin
                    gd[k] = qd[k][0];
                    gs[k] = qs[k][0];
                    qd[k][0] = qd[k][1];
                    qs[k][0] = qs[k][1];
                    qn[k] = qn[k] - 1;
                end
                if (ifire[k]) begin
                    qd[k][qn[k]] = in_data;
                    qs[k][qn[k]] = in_stat;
                    qn[k] = qn[k] + 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_dut(input int k, input logic ir, input logic ov,
                             input logic [63:0] od, input logic [2:0] os,
                             input logic [15:0] scv, input logic [15:0] bcv,
                             input logic cev);
        logic [63:0] ed;
        logic [2:0]  es;
        ed = (qn[k] > 0) ? qd[k][0] : gd[k];
        es = (qn[k] > 0) ? qs[k][0] : gs[k];
        chk($sformatf("dut%0d.in_ready", k),   {63'd0, ir}, {63'd0, exp_in_ready(k)});
        chk($sformatf("dut%0d.out_valid", k),  {63'd0, ov}, {63'd0, exp_out_valid(k)});
        chk($sformatf("dut%0d.out_data", k),   od, ed);
        chk($sformatf("dut%0d.out_stat", k),   {61'd0, os}, {61'd0, es});
        chk($sformatf("dut%0d.stall_cnt", k),  {48'd0, scv}, 64'(sc[k]));
        chk($sformatf("dut%0d.bubble_cnt", k), {48'd0, bcv}, 64'(bc[k]));
        chk($sformatf("dut%0d.ctl_err", k),    {63'd0, cev}, {63'd0, ce[k]});
    endtask

    // one cycle: settle, compare, advance the model across the rising edge
    task automatic tick();
        #1;
        check_dut(0, in_ready0, out_valid0, out_data0, out_stat0,
                  stall_cnt0, bubble_cnt0, ctl_err0);
        check_dut(1, in_ready1, out_valid1, out_data1, out_stat1,
                  {12'd0, stall_cnt1}, {12'd0, bubble_cnt1}, ctl_err1);
        for (int k = 0; k < 2; k++) begin
            ifire[k] = in_valid && exp_in_ready(k);
            ofire[k] = exp_out_valid(k) && out_ready;
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        in_stat   = 3'($urandom_range(1, 4));
        out_ready = ordy;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; bubble = 1'b0;
        in_valid = 1'b0; in_data = 64'h0; in_stat = 3'd1; out_ready = 1'b0;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // fill with downstream blocked, then drain in order
        drive(1'b1, 64'h10, 1'b0); tick();
        drive(1'b1, 64'h11, 1'b0); tick();
        drive(1'b1, 64'h12, 1'b0); tick();
        drive(1'b1, 64'h12, 1'b1); tick();
        drive(1'b1, 64'h12, 1'b1); tick();
        drive(1'b0, 64'h0,  1'b1); tick();
        tick();
        tick();

        // back-to-back streaming
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, {$urandom, $urandom}, 1'b1);
            tick();
        end
        drive(1'b0, 64'h0, 1'b1); tick();

        // stall holding a valid 0xAA entry
        drive(1'b1, 64'hAA, 1'b0); tick();
        drive(1'b0, 64'h0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        stall = 1'b0;
        out_ready = 1'b1; tick();
        tick();

        // fill both slots, then bubble
        drive(1'b1, 64'h21, 1'b0); tick();
        drive(1'b1, 64'h22, 1'b0); tick();
        drive(1'b0, 64'h0, 1'b0);
        bubble = 1'b1; tick();
        bubble = 1'b0; tick();
        out_ready = 1'b1; tick();

        // stall and bubble together: flush, both counters, sticky error
        drive(1'b1, 64'h31, 1'b0); tick();
        stall = 1'b1; bubble = 1'b1; tick();
        stall = 1'b0; bubble = 1'b0;
        drive(1'b1, 64'h32, 1'b1); tick();
        tick();

        // long stall saturates the 4-bit counter
        stall = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        stall = 1'b0; tick();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
            stall  = ($urandom_range(0, 7) == 0);
            bubble = ($urandom_range(0, 15) == 0);
            tick();
        end
        stall = 1'b0; bubble = 1'b0;

        // reset mid-stream with slots full
        drive(1'b1, 64'h41, 1'b0); tick();
        drive(1'b1, 64'h42, 1'b0); tick();
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        tick();
        rst = 1'b0;
        drive(1'b1, 64'h51, 1'b1); tick();
        tick();
        drive(1'b0, 64'h0, 1'b1); tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic Y86-64 pipeline stage register that replaces the fixed per-stage registers (F/D/E/M/W) with one parametrised block.
- Adds ready/valid flow control, stall (hold) and bubble (flush to nop) control, and an optional skid slot so `in_ready` is registered.
- Provides saturating stall/bubble event counters and a sticky control-conflict flag for pipeline-control debug.

Parameters:
- WIDTH, 64: payload width in bits.
- STAT_W, 3: status-field width.
- SKID, 1: 1 = two-entry (main + skid) with registered `in_ready`; 0 = single entry with combinational `in_ready`.
- BUBBLE_DATA, 0: payload loaded on bubble or reset.
- BUBBLE_STAT, 1: status loaded on bubble or reset (STAT_AOK).
- CNT_W, 16: event-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold stage contents this cycle.
- bubble  in  1  flush stage to nop this cycle.
- in_valid  in  1  upstream payload valid.
- in_data  in  WIDTH  upstream payload.
- in_stat  in  STAT_W  upstream status.
- in_ready  out  1  stage can accept.
- out_valid  out  1  stage holds a valid entry.
- out_data  out  WIDTH  head payload.
- out_stat  out  STAT_W  head status.
- out_ready  in  1  downstream accepts.
- stall_cnt  out  CNT_W  cycles with stall=1 (saturating).
- bubble_cnt  out  CNT_W  cycles with bubble=1 (saturating).
- ctl_err  out  1  sticky; set when stall and bubble are both high.

Behaviour:
- State:
  - Main slot M (valid, data, stat).
  - Skid slot S (valid, data, stat); present only when SKID=1.
- Reset (rst=1, asynchronous):
  - M.valid=0, S.valid=0.
  - M/S data=BUBBLE_DATA, stat=BUBBLE_STAT.
  - Counters=0, ctl_err=0.
  - Therefore out_valid=0, out_data=BUBBLE_DATA, out_stat=BUBBLE_STAT.
  - in_ready=0 while rst is high. After release, in_ready=1 in the first cycle.
- Output side: out_data/out_stat always equal M's contents; out_valid = M.valid & ~stall & ~bubble.
- Fire conditions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Priority: rst > bubble > stall > normal flow.
- Bubble:
  - M and S are loaded with the bubble value and marked invalid; in_ready=0.
  - Any entry in S is discarded.
  - bubble_cnt increments.
- Stall (bubble=0):
  - All slots hold; in_ready=0; out_valid=0.
  - stall_cnt increments.
- stall & bubble together: bubble wins, both counters increment, ctl_err is set and stays set until rst.
- Normal flow, SKID=1:
  - in_ready = ~S.valid (registered-equivalent: it depends only on state, not on out_ready).
  - out_fire & S.valid: M<=S; S empties.
  - in_fire & (~M.valid | out_fire): M<=in.
  - in_fire & M.valid & ~out_fire: S<=in.
  - out_fire & ~in_fire & ~S.valid: M.valid<=0; data and stat hold their last value.
- Normal flow, SKID=0:
  - in_ready = ~M.valid | out_ready.
  - in_fire: M<=in.
  - out_fire & ~in_fire: M.valid<=0.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Throughput is one entry per cycle in both modes.
- Counters saturate at all-ones and never wrap.
- Ordering: entries are strictly FIFO. No entry is duplicated or dropped except by bubble.

Decomposition:
- pipe_pkg holds:
  - STAT_AOK=1, STAT_HLT=2, STAT_ADR=3, STAT_INS=4.
  - STAT_W.
  - Default bubble constants per stage, e.g. the nop icode/ifun encoding for regD/regE payloads.
- One sub-module, pipe_slot: a single valid+data+stat register with load, clear-to-bubble and hold controls. It is instantiated for M always and for S when SKID=1 (generate).

Test Plan:
1. Reset mid-stream (M and S full) → next edge: out_valid=0, out_data=BUBBLE_DATA, out_stat=1, counters=0, in_ready=1 after release.
2. SKID=1: stream 0x10,0x11,0x12 with out_ready held 0 → in_ready drops after 2 accepts. Set out_ready=1 → outputs 0x10,0x11,0x12 in order, no loss.
3. Back-to-back stream with out_ready=1, both SKID values → one output per cycle, data equal to input delayed by 1 cycle.
4. M=0xAA valid, stall for 3 cycles → out_valid=0 and in_ready=0 for 3 cycles, out_data=0xAA held, stall_cnt=3. Release → 0xAA delivered.
5. M and S full, pulse bubble → both invalid, out_data=BUBBLE_DATA, bubble_cnt=1, ctl_err=0.
6. Assert stall & bubble together → flush occurs, stall_cnt and bubble_cnt both +1, ctl_err=1 and stays 1 until rst; counter forced near max saturates at 0xFFFF.
